// File: rtl/alu_dispatcher_if.sv
// Bundle of every signal between alu_dispatcher and its surroundings.
// The names keep the i_/o_ direction prefixes as seen from the dispatcher.
// master: the dispatcher side. slave: the byte link and ALU side.
interface alu_dispatcher_if #(
  parameter int bitness = 8
);
  logic               i_rx_valid;
  logic [7:0]         i_rx_data;
  logic               o_alu_ready;
  logic [7:0]         o_alu_op;
  logic [bitness-1:0] o_alu_num_1;
  logic [bitness-1:0] o_alu_num_2;
  logic               i_alu_ready;
  logic [bitness-1:0] i_alu_hi;
  logic [bitness-1:0] i_alu_lo;
  logic               o_tx_valid;
  logic [7:0]         o_tx_data;
  logic               i_tx_busy;
  logic               o_busy;
  logic               o_overrun;

  modport master (
    input  i_rx_valid, i_rx_data, i_alu_ready, i_alu_hi, i_alu_lo, i_tx_busy,
    output o_alu_ready, o_alu_op, o_alu_num_1, o_alu_num_2,
           o_tx_valid, o_tx_data, o_busy, o_overrun
  );

  modport slave (
    output i_rx_valid, i_rx_data, i_alu_ready, i_alu_hi, i_alu_lo, i_tx_busy,
    input  o_alu_ready, o_alu_op, o_alu_num_1, o_alu_num_2,
           o_tx_valid, o_tx_data, o_busy, o_overrun
  );
endinterface

// File: rtl/alu_dispatcher.sv
// alu_dispatcher: collects a 3-byte command frame (op, operand 1, operand 2),
// issues it once to the coprocessor ALU, waits for completion or timeout and
// streams back a 3-byte response (status, result Hi, result Lo).
// Status codes: 0x00 ok, 0x01 ALU timeout, 0x02 illegal op, 0x03 divide by 0.
// Optional feature macro: DIV_ZERO_CHECK_EN -- when defined, op 0x04 with a
// zero second operand is rejected locally with status 0x03 instead of being
// sent to the ALU.
module alu_dispatcher #(
  parameter int bitness = 8,
  parameter int TIMEOUT = 16
) (
  input logic              i_clk,
  input logic              reset,
  alu_dispatcher_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, GET_A, GET_B, CHECK, ISSUE, WAIT, SEND_ST, SEND_HI, SEND_LO
  } state_t;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_TIMEOUT = 8'h01;
  localparam logic [7:0] ST_BAD_OP  = 8'h02;
  localparam logic [7:0] ST_DIV0    = 8'h03;
  // WAIT ends when the counter would reach TIMEOUT, so WAIT lasts at most
  // TIMEOUT cycles.
  localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

  // ALU results are bitness wide; the link always carries full bytes.
  function automatic logic [7:0] zext(input logic [bitness-1:0] v);
    return 8'(v);
  endfunction

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] status_r;
  logic [7:0] hi_r;
  logic [7:0] lo_r;
  logic       op_legal;
  logic       div_zero;
  logic       framing;

  assign op_legal = (bus.o_alu_op >= 8'h01) && (bus.o_alu_op <= 8'h04);
  assign framing  = (state == IDLE) || (state == GET_A) || (state == GET_B);

`ifdef DIV_ZERO_CHECK_EN
  assign div_zero = (bus.o_alu_op == 8'h04) && (bus.o_alu_num_2 == '0);
`else
  assign div_zero = 1'b0;
`endif

  // Command/response sequencer; every output is a register written here.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      status_r        <= '0;
      hi_r            <= '0;
      lo_r            <= '0;
      bus.o_alu_ready <= 1'b0;
      bus.o_alu_op    <= '0;
      bus.o_alu_num_1 <= '0;
      bus.o_alu_num_2 <= '0;
      bus.o_tx_valid  <= 1'b0;
      bus.o_tx_data   <= '0;
      bus.o_busy      <= 1'b0;
      bus.o_overrun   <= 1'b0;
    end else begin
      bus.o_alu_ready <= 1'b0;
      // Bytes arriving while a frame is being processed are dropped.
      bus.o_overrun   <= bus.i_rx_valid && !framing;

      case (state)
        IDLE: begin
          if (bus.i_rx_valid) begin
            bus.o_alu_op <= bus.i_rx_data;
            bus.o_busy   <= 1'b1;
            state        <= GET_A;
          end
        end

        GET_A: begin
          if (bus.i_rx_valid) begin
            bus.o_alu_num_1 <= bus.i_rx_data[bitness-1:0];
            state           <= GET_B;
          end
        end

        GET_B: begin
          if (bus.i_rx_valid) begin
            bus.o_alu_num_2 <= bus.i_rx_data[bitness-1:0];
            state           <= CHECK;
          end
        end

        // Rejected commands answer immediately without touching the ALU.
        CHECK: begin
          if (!op_legal) begin
            status_r <= ST_BAD_OP;
            hi_r     <= '0;
            lo_r     <= '0;
            state    <= SEND_ST;
          end else if (div_zero) begin
            status_r <= ST_DIV0;
            hi_r     <= '0;
            lo_r     <= '0;
            state    <= SEND_ST;
          end else begin
            bus.o_alu_ready <= 1'b1;
            state           <= ISSUE;
          end
        end

        // o_alu_ready is high for exactly this one cycle.
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end

        // A completion in the terminal-count cycle still reports the result.
        WAIT: begin
          if (bus.i_alu_ready) begin
            status_r <= ST_OK;
            hi_r     <= zext(bus.i_alu_hi);
            lo_r     <= zext(bus.i_alu_lo);
            state    <= SEND_ST;
          end else if (cnt == CNT_LAST) begin
            status_r <= ST_TIMEOUT;
            hi_r     <= '0;
            lo_r     <= '0;
            state    <= SEND_ST;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        // First cycle loads the status byte; afterwards wait for acceptance.
        SEND_ST: begin
          if (!bus.o_tx_valid) begin
            bus.o_tx_valid <= 1'b1;
            bus.o_tx_data  <= status_r;
          end else if (!bus.i_tx_busy) begin
            bus.o_tx_data <= hi_r;
            state         <= SEND_HI;
          end
        end

        SEND_HI: begin
          if (!bus.i_tx_busy) begin
            bus.o_tx_data <= lo_r;
            state         <= SEND_LO;
          end
        end

        SEND_LO: begin
          if (!bus.i_tx_busy) begin
            bus.o_tx_valid <= 1'b0;
            bus.o_tx_data  <= '0;
            bus.o_busy     <= 1'b0;
            state          <= IDLE;
          end
        end

        default: begin
          bus.o_tx_valid <= 1'b0;
          bus.o_busy     <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
